// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration checks for the digit-serial adder.
// The parameter-check macro is file-scope so any module can expand it as a generate item.
`ifndef SERIAL_ADDER_PKG_SV
`define SERIAL_ADDER_PKG_SV

package serial_adder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Counter width for n digit steps; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

`define SERIAL_ADDER_CHECK_DIGIT(W, D) \
   if ((W) < 1 || (D) < 1 || ((W) % (D)) != 0) begin : g_bad_digit \
      $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly"); \
   end

`endif

// File: rtl/serial_adder_adder_slice.sv
// DIGIT-bit ripple of full-adder cells, also exposing the carry into its top bit
// so the parent can form the two's-complement overflow flag on the last digit.
module adder_slice #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic c;

   always_comb begin
      s     = '0;
      c     = ci;
      c_msb = ci;
      for (int i = 0; i < DIGIT; i++) begin
         s[i] = x[i] ^ y[i] ^ c;
         if (i == DIGIT - 1) c_msb = c;
         c = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      co = c;
   end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: {cout,sum} = a + b + cin, DIGIT bits per clock over WIDTH/DIGIT cycles,
// with a start/busy/done handshake and two's-complement overflow detection.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = cnt_w(N);

   `SERIAL_ADDER_CHECK_DIGIT(WIDTH, DIGIT)

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] psum;
   logic [WIDTH-1:0] psum_nxt;
   logic [WIDTH-1:0] sum_r;
   logic             carry;
   logic             cout_r;
   logic             ovf_r;
   logic             done_r;
   logic [DIGIT-1:0] s_dig;
   logic             co_dig;
   logic             cmsb_dig;
   logic             last;

   adder_slice #(.DIGIT(DIGIT)) u_slice (
      .x     (a_sr[DIGIT-1:0]),
      .y     (b_sr[DIGIT-1:0]),
      .ci    (carry),
      .s     (s_dig),
      .co    (co_dig),
      .c_msb (cmsb_dig)
   );

   assign last = (cnt == CW'(N - 1));

   // New digit enters at the top; after N steps the first digit has reached bit 0.
   assign psum_nxt = WIDTH'({s_dig, psum} >> DIGIT);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      if (state == RUN) busy = 1'b1;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt    <= '0;
         a_sr   <= '0;
         b_sr   <= '0;
         psum   <= '0;
         carry  <= 1'b0;
         sum_r  <= '0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               a_sr  <= a;
               b_sr  <= b;
               carry <= cin;
               cnt   <= '0;
            end
         end else begin
            a_sr  <= a_sr >> DIGIT;
            b_sr  <= b_sr >> DIGIT;
            carry <= co_dig;
            psum  <= psum_nxt;
            cnt   <= cnt + CW'(1);
            // On the final digit the slice's top-bit carry-in is the carry into bit WIDTH-1.
            if (last) begin
               sum_r  <= psum_nxt;
               cout_r <= co_dig;
               ovf_r  <= cmsb_dig ^ co_dig;
               done_r <= 1'b1;
            end
         end
      end
   end

   assign done     = done_r;
   assign sum      = sum_r;
   assign cout     = cout_r;
   assign overflow = ovf_r;

endmodule
